// File: rtl/cdm_pipe_mul.sv
// Pipelined carry-disregard approximate multiplier with valid/ready streaming,
// per-transaction exact/approximate mode and a saturating approximate-result counter.
module cdm_pipe_mul #(
    parameter int unsigned W    = 8,
    parameter int unsigned K_LO = 2,
    parameter int unsigned K_HI = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_a,
    input  logic [W-1:0]     in_b,
    input  logic             in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*W-1:0]   out_r,
    output logic             out_mode,
    output logic [15:0]      approx_cnt
);

    localparam int unsigned NB = W / 4;
    localparam int unsigned PW = W + 4;
    localparam int unsigned RW = 2 * W;

    // Nibble partial: low k columns keep only parity, columns >= k summed exactly.
    function automatic logic [PW-1:0] nib_partial(input logic [W-1:0] a,
                                                  input logic [3:0]   bn,
                                                  input int unsigned  k);
        logic [PW-1:0] row;
        logic [PW-1:0] par;
        logic [PW-1:0] hi;
        logic [PW-1:0] low_mask;
        par = '0;
        hi  = '0;
        for (int unsigned c = 0; c < PW; c++) begin
            low_mask[c] = (c < k);
        end
        for (int i = 0; i < 4; i++) begin
            row = bn[i] ? (PW'(a) << i) : '0;
            par = par ^ (row & low_mask);
            hi  = hi + (row & ~low_mask);
        end
        return par + hi;
    endfunction

    logic                     s1_valid_q, s1_valid_d;
    logic [W-1:0]             s1_a_q, s1_a_d;
    logic [W-1:0]             s1_b_q, s1_b_d;
    logic                     s1_mode_q, s1_mode_d;
    logic                     s2_valid_q, s2_valid_d;
    logic [NB-1:0][PW-1:0]    s2_p_q, s2_p_d;
    logic                     s2_mode_q, s2_mode_d;
    logic                     s3_valid_q, s3_valid_d;
    logic [RW-1:0]            s3_r_q, s3_r_d;
    logic                     s3_mode_q, s3_mode_d;
    logic [15:0]              cnt_q, cnt_d;
    logic                     en_c;
    logic [NB-1:0][PW-1:0]    part_c;
    logic [RW-1:0]            sum_c;

    // Partials from S1 and their exact sum from S2.
    always_comb begin
        int unsigned kj;
        part_c = '0;
        sum_c  = '0;
        for (int j = 0; j < int'(NB); j++) begin
            kj = 0;
            if (s1_mode_q) begin
                kj = (j < int'(NB / 2)) ? K_LO : K_HI;
            end
            part_c[j] = nib_partial(s1_a_q, s1_b_q[4*j +: 4], kj);
        end
        for (int j = 0; j < int'(NB); j++) begin
            sum_c = sum_c + (RW'(s2_p_q[j]) << (4 * j));
        end
    end

    // Global advance enable, stage next-state and counter update.
    always_comb begin
        en_c       = !s3_valid_q || out_ready;
        s1_valid_d = s1_valid_q;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        s1_mode_d  = s1_mode_q;
        s2_valid_d = s2_valid_q;
        s2_p_d     = s2_p_q;
        s2_mode_d  = s2_mode_q;
        s3_valid_d = s3_valid_q;
        s3_r_d     = s3_r_q;
        s3_mode_d  = s3_mode_q;
        cnt_d      = cnt_q;
        if (en_c) begin
            s1_valid_d = in_valid;
            s1_a_d     = in_a;
            s1_b_d     = in_b;
            s1_mode_d  = in_mode;
            s2_valid_d = s1_valid_q;
            s2_p_d     = part_c;
            s2_mode_d  = s1_mode_q;
            s3_valid_d = s2_valid_q;
            s3_r_d     = sum_c;
            s3_mode_d  = s2_mode_q;
        end
        if (s3_valid_q && out_ready && s3_mode_q && (cnt_q != 16'hFFFF)) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    // Pipeline and counter registers; reset discards in-flight work.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_mode_q  <= 1'b0;
            s2_valid_q <= 1'b0;
            s2_p_q     <= '0;
            s2_mode_q  <= 1'b0;
            s3_valid_q <= 1'b0;
            s3_r_q     <= '0;
            s3_mode_q  <= 1'b0;
            cnt_q      <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_a_q     <= s1_a_d;
            s1_b_q     <= s1_b_d;
            s1_mode_q  <= s1_mode_d;
            s2_valid_q <= s2_valid_d;
            s2_p_q     <= s2_p_d;
            s2_mode_q  <= s2_mode_d;
            s3_valid_q <= s3_valid_d;
            s3_r_q     <= s3_r_d;
            s3_mode_q  <= s3_mode_d;
            cnt_q      <= cnt_d;
        end
    end

    assign in_ready   = en_c;
    assign out_valid  = s3_valid_q;
    assign out_r      = s3_r_q;
    assign out_mode   = s3_mode_q;
    assign approx_cnt = cnt_q;

endmodule
